// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Instruction fetch controller. It owns the program counter and runs a
// four-state machine: RST -> FETCH (request) -> WAIT (await read data)
// -> HOLD (offer the instruction to decode) -> FETCH ...
// A resolved redirect overrides the sequential pc+4 in every state, and
// any read data still in flight when a redirect arrives is discarded.
//
// Optional feature (compile-time macro):
//   PC_FETCH_MISALIGN_TRAP_EN  defined   : a redirect whose target has
//                                          bits [1:0] != 0 loads TRAP_VEC
//                                          and pulses trap for one cycle.
//                              undefined : target bits [1:0] are forced
//                                          to 0 and trap stays low.
//
// Parameters:
//   mode      width of pc, fetch address and redirect target
//   RESET_PC  first fetch address
//   TRAP_VEC  misaligned-redirect target
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   imem_req, imem_addr      fetch request and address (held until grant)
//   imem_gnt                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata  returned instruction word
//   if_valid, if_instr,      instruction offered to decode, with its pc
//   if_pc
//   if_ready                 decode consumes the offered instruction
//   redir_valid, redir_pc    taken branch/jump and its target
//   trap                     one-cycle pulse on a misaligned redirect
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int                mode     = 32,
  parameter logic [mode-1:0]   RESET_PC = mode'(32'h0000_0000),
  parameter logic [mode-1:0]   TRAP_VEC = mode'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [mode-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [mode-1:0] if_pc,
  input  logic            if_ready,
  input  logic            redir_valid,
  input  logic [mode-1:0] redir_pc,
  output logic            trap
);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [mode-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            capture;
  logic            trap_q;

  // Target actually loaded on a redirect: misaligned targets either trap
  // or are silently aligned down, depending on the build.
  function automatic logic [mode-1:0] redir_target(input logic [mode-1:0] tgt);
    if (TRAP_EN && (tgt[1:0] != 2'b00)) return TRAP_VEC;
    return {tgt[mode-1:2], 2'b00};
  endfunction

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    capture  = 1'b0;
    imem_req = 1'b0;
    if_valid = 1'b0;

    case (state_q)
      RST: state_d = FETCH;

      FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_d = WAIT;
          // A grant that coincides with a redirect still owes us a
          // response; mark it so WAIT throws it away.
          kill_d  = redir_valid;
        end
      end

      WAIT: begin
        if (redir_valid) kill_d = 1'b1;
        if (imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = FETCH;
          if (!kill_q && !redir_valid) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if_valid = 1'b1;
        if (if_ready) begin
          pc_d    = pc_q + mode'(4);
          state_d = FETCH;
        end
      end

      default: state_d = RST;
    endcase

    // Redirect wins over everything above, in every state.
    if (redir_valid) begin
      pc_d     = redir_target(redir_pc);
      if_valid = 1'b0;
      if (state_q == HOLD) state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RST;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      trap_q   <= 1'b0;
      if_instr <= NOP;
      if_pc    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      trap_q  <= TRAP_EN && redir_valid && (redir_pc[1:0] != 2'b00);
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc_q;
      end
    end
  end

  assign imem_addr = pc_q;
  assign trap      = trap_q;

endmodule
